float_mul_seq: RTL and testbench



---
 rtl/float_mul_seq.sv | 187 ++++++++++++++++++
 tb/tb_float_mul_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/float_mul_seq.sv
// float_mul_seq: sequential IEEE-754 single-precision multiplier with operation_nd/operation_rfd/rdy handshake
// Ports: clk, rst (async, active-low); a, b operands captured on operation_nd while operation_rfd;
//        result/underflow/overflow/invalid_op held until the next completion, rdy pulses one cycle when they update.
// Build option: FMUL_FAST_MUL_EN selects a single-cycle combinational mantissa multiply instead of 24-step shift-add.
module float_mul_seq #(
  parameter int SF_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SF_WIDTH-1:0] a,
  input  logic [SF_WIDTH-1:0] b,
  input  logic                operation_nd,
  output logic                operation_rfd,
  output logic [SF_WIDTH-1:0] result,
  output logic                underflow,
  output logic                overflow,
  output logic                invalid_op,
  output logic                rdy
);
  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM_RND, DONE} state_t;
  localparam logic [2:0] SP_NONE = 3'd0, SP_INV = 3'd1, SP_QNAN = 3'd2, SP_INF = 3'd3, SP_ZERO = 3'd4;
  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d, result_q, result_d;
  logic [23:0]         ma_q, ma_d, mb_q, mb_d;
  logic [47:0]         acc_q, acc_d;
  logic signed [9:0]   exp_q, exp_d;
  logic                sign_q, sign_d, uf_q, uf_d, of_q, of_d, inv_q, inv_d, rdy_q, rdy_d;
  logic [2:0]          spec_q, spec_d;
  logic [22:0]         frac_q, frac_d;
`ifndef FMUL_FAST_MUL_EN
  logic [4:0]          cnt_q, cnt_d;
  logic [24:0]         step_sum;
  assign step_sum = {1'b0, acc_q[47:24]} + {1'b0, ma_q[0] ? mb_q : 24'h0};
`endif
  logic [7:0]  ea, eb;
  logic        za, zb, ia, ib, qa, qb, sa, sb;
  logic [2:0]  spec_c;
  assign ea = a_q[30:23];
  assign eb = b_q[30:23];
  // denormals share the exponent-zero class and are flushed like zero
  assign za = ea == 8'h00;
  assign zb = eb == 8'h00;
  assign ia = ea == 8'hFF && a_q[22:0] == 23'h0;
  assign ib = eb == 8'hFF && b_q[22:0] == 23'h0;
  assign qa = ea == 8'hFF && a_q[22];
  assign qb = eb == 8'hFF && b_q[22];
  assign sa = ea == 8'hFF && !a_q[22] && a_q[21:0] != 22'h0;
  assign sb = eb == 8'hFF && !b_q[22] && b_q[21:0] != 22'h0;
  assign spec_c = (sa | sb) ? SP_INV :
                  (qa | qb) ? SP_QNAN :
                  ((za & ib) | (ia & zb)) ? SP_INV :
                  (ia | ib) ? SP_INF :
                  (za | zb) ? SP_ZERO : SP_NONE;
  logic              hi, g, r, s, up;
  logic [23:0]       mant;
  logic [24:0]       rnd;
  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;
  assign hi     = acc_q[47];
  assign mant   = hi ? acc_q[47:24] : acc_q[46:23];
  assign g      = hi ? acc_q[23] : acc_q[22];
  assign r      = hi ? acc_q[22] : acc_q[21];
  assign s      = hi ? |acc_q[21:0] : |acc_q[20:0];
  assign up     = g & (r | s | mant[0]);
  assign rnd    = {1'b0, mant} + {24'h0, up};
  // a rounding carry-out leaves 1.000..0, so the fraction is simply the shifted value
  assign exp_n  = exp_q + $signed({9'h0, hi}) + $signed({9'h0, rnd[24]});
  assign frac_n = rnd[24] ? rnd[23:1] : rnd[22:0];
  logic ovf, unf;
  assign ovf = exp_q >= 10'sd255;
  assign unf = exp_q <= 10'sd0;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    spec_d   = spec_q;
    frac_d   = frac_q;
    result_d = result_q;
    uf_d     = uf_q;
    of_d     = of_q;
    inv_d    = inv_q;
    rdy_d    = 1'b0;
`ifndef FMUL_FAST_MUL_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: if (operation_nd) begin
        a_d     = a;
        b_d     = b;
        state_d = UNPACK;
      end
      UNPACK: begin
        ma_d    = {1'b1, a_q[22:0]};
        mb_d    = {1'b1, b_q[22:0]};
        sign_d  = a_q[31] ^ b_q[31];
        exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        spec_d  = spec_c;
        acc_d   = 48'h0;
`ifndef FMUL_FAST_MUL_EN
        cnt_d   = 5'd0;
`endif
        state_d = MUL;
      end
      MUL: begin
`ifdef FMUL_FAST_MUL_EN
        acc_d   = {24'h0, ma_q} * {24'h0, mb_q};
        state_d = NORM_RND;
`else
        // right-shifting accumulator: after 24 steps acc holds ma*mb
        acc_d   = {step_sum, acc_q[23:1]};
        ma_d    = ma_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        state_d = cnt_q == 5'd23 ? NORM_RND : MUL;
`endif
      end
      NORM_RND: begin
        exp_d   = exp_n;
        frac_d  = frac_n;
        state_d = DONE;
      end
      DONE: begin
        result_d = (spec_q == SP_INV || spec_q == SP_QNAN) ? 32'h7FC00000 :
                   (spec_q == SP_INF || (spec_q == SP_NONE && ovf)) ? {sign_q, 8'hFF, 23'h0} :
                   (spec_q == SP_ZERO || (spec_q == SP_NONE && unf)) ? {sign_q, 31'h0} :
                   {sign_q, exp_q[7:0], frac_q};
        of_d     = spec_q == SP_NONE && ovf;
        uf_d     = spec_q == SP_NONE && unf;
        inv_d    = spec_q == SP_INV;
        rdy_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      spec_q   <= SP_NONE;
      frac_q   <= '0;
      result_q <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
      inv_q    <= 1'b0;
      rdy_q    <= 1'b0;
`ifndef FMUL_FAST_MUL_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      spec_q   <= spec_d;
      frac_q   <= frac_d;
      result_q <= result_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
      inv_q    <= inv_d;
      rdy_q    <= rdy_d;
`ifndef FMUL_FAST_MUL_EN
      cnt_q    <= cnt_d;
`endif
    end
  end
  assign operation_rfd = state_q == IDLE;
  assign result        = result_q;
  assign underflow     = uf_q;
  assign overflow      = of_q;
  assign invalid_op    = inv_q;
  assign rdy           = rdy_q;
endmodule

// File: tb/tb_float_mul_seq.sv
// tb_float_mul_seq: scoreboard bench for float_mul_seq with an arithmetic reference model
module tb_float_mul_seq;
`ifdef FMUL_FAST_MUL_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 27;
`endif
  logic        clk = 1'b0, rst = 1'b0, operation_nd = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        operation_rfd, underflow, overflow, invalid_op, rdy;
  logic [31:0] result;
  int          checks = 0, errors = 0, cyc = 0;
  logic [34:0] expq[$];
  int          capq[$];
  logic [34:0] last = '0;
  float_mul_seq #(.SF_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .operation_nd(operation_nd),
    .operation_rfd(operation_rfd), .result(result), .underflow(underflow),
    .overflow(overflow), .invalid_op(invalid_op), .rdy(rdy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // expected {result, underflow, overflow, invalid_op} from the IEEE rules using integer arithmetic
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s, zx, zy, ix, iy, qx, qy, nx, ny;
    int ex, ey, e, sh;
    longint unsigned p, q, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    zx = ex == 0; zy = ey == 0;
    ix = ex == 255 && x[22:0] == 0; iy = ey == 255 && y[22:0] == 0;
    qx = ex == 255 && x[22]; qy = ey == 255 && y[22];
    nx = ex == 255 && !x[22] && x[22:0] != 0; ny = ey == 255 && !y[22] && y[22:0] != 0;
    if (nx || ny) return {32'h7FC00000, 3'b001};
    if (qx || qy) return {32'h7FC00000, 3'b000};
    if ((zx && iy) || (ix && zy)) return {32'h7FC00000, 3'b001};
    if (ix || iy) return {s, 8'hFF, 23'h0, 3'b000};
    if (zx || zy) return {s, 31'h0, 3'b000};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e = ex + ey - 127;
    sh = (p >> 47) != 0 ? 24 : 23;
    e = e + sh - 23;
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b010};
    if (e <= 0) return {s, 31'h0, 3'b100};
    return {s, 8'(e), q[22:0], 3'b000};
  endfunction
  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    k = $urandom_range(0, 15);
    v = $urandom;
    case (k)
      0: v[30:23] = 8'h00;
      1: v[30:0] = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: v[30:0] = {8'hFF, 1'b0, 22'($urandom_range(1, 22'h3FFFFF))};
      4: v[30:23] = 8'($urandom_range(200, 254));
      5: v[30:23] = 8'($urandom_range(1, 60));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    int t = 0;
    while (!operation_rfd && t < 100) begin @(negedge clk); t++; end
    if (!operation_rfd) begin
      checks++; errors++;
      $display("FAIL issue_timeout: operation_rfd=%0b required 1", operation_rfd);
      return;
    end
    a = x; b = y; operation_nd = 1'b1;
    expq.push_back(model(x, y));
    capq.push_back(cyc + 1);
    @(negedge clk);
    operation_nd = 1'b0;
    checks++;
    if (operation_rfd !== 1'b0) begin
      errors++;
      $display("FAIL rfd_drop: operation_rfd=%0b required 0", operation_rfd);
    end
  endtask
  always @(negedge clk) begin
    logic [34:0] got, e;
    int c;
    got = {result, underflow, overflow, invalid_op};
    if (!rst) last = '0;
    else if (rdy) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_rdy: result=%h with no operation pending", result);
      end else begin
        e = expq.pop_front();
        c = capq.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL result: got %h uf=%0b of=%0b inv=%0b, required %h uf=%0b of=%0b inv=%0b",
                   got[34:3], got[2], got[1], got[0], e[34:3], e[2], e[1], e[0]);
        end
        checks++;
        if (cyc - c != LAT) begin
          errors++;
          $display("FAIL latency: got %0d edges, required %0d", cyc - c, LAT);
        end
      end
      last = got;
    end else begin
      checks++;
      if (got !== last) begin
        errors++;
        $display("FAIL hold: outputs %h changed without rdy, required %h", got, last);
      end
    end
  end
  logic [31:0] dir_a[10] = '{32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3F800000, 32'h7F000000,
                             32'h00800000, 32'h00000000, 32'h7F800001, 32'h7FC00000, 32'hFF800000};
  logic [31:0] dir_b[10] = '{32'h40400000, 32'h40400000, 32'h3F800001, 32'h41200000, 32'h40000000,
                             32'h3F000000, 32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
  initial begin
    int t;
    #1;
    checks++;
    if ({operation_rfd, rdy, result, underflow, overflow, invalid_op} !== {2'b10, 35'h0}) begin
      errors++;
      $display("FAIL reset_state: rfd=%0b rdy=%0b result=%h flags=%0b%0b%0b, required rfd=1 rdy=0 result=0 flags=000",
               operation_rfd, rdy, result, underflow, overflow, invalid_op);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) issue(dir_a[i], dir_b[i]);
    issue(32'h40000000, 32'h40400000);
    repeat (5) @(negedge clk);
    checks++;
    if (operation_rfd !== 1'b0) begin
      errors++;
      $display("FAIL busy_rfd: operation_rfd=%0b required 0", operation_rfd);
    end
    a = 32'h7F800000; b = 32'h00000000; operation_nd = 1'b1;
    @(negedge clk);
    operation_nd = 1'b0;
    issue(32'h3FC00000, 32'h3FC00000);
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({operation_rfd, rdy, result} !== {2'b10, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset: rfd=%0b rdy=%0b result=%h, required rfd=1 rdy=0 result=0",
               operation_rfd, rdy, result);
    end
    expq.delete();
    capq.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(32'h3F800000, 32'h3F800000);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(rnd_op(), rnd_op());
    end
    t = 0;
    while (expq.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (expq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results outstanding, required 0", expq.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
